// File: rtl/tt_ctrl_seq.sv
// Sequencer that selects one design on the mux chain by resetting and stepping the selection counter.
// Optional fast reselection (skips the chain reset when stepping forward) is enabled by `TT_CTRL_SEQ_FASTSEL_EN.
module tt_ctrl_seq #(
    parameter int RST_HOLD      = 2,
    parameter int UM_RST_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sel_addr,
    input  logic       sel_req,
    output logic       sel_ack,
    input  logic       sel_off,
    output logic       busy,
    output logic       done,
    output logic [9:0] cur_addr,
    output logic       ctrl_sel_rst_n,
    output logic       ctrl_sel_inc,
    output logic       ctrl_ena,
    output logic       um_rst_n
);

    typedef enum logic [2:0] {
        IDLE,
        DIS,
        SRST,
        INC_HI,
        INC_LO,
        URST,
        RUN
    } state_e;

    localparam logic [7:0] SRST_LOAD = 8'(RST_HOLD - 1);
    localparam logic [7:0] URST_LOAD = 8'(UM_RST_CYCLES - 1);

    state_e     state_q, state_d;
    logic [9:0] tgt_q, tgt_d;
    logic [9:0] cur_q, cur_d;
    logic [7:0] cnt_q, cnt_d;
    logic       off_q, off_d;
    logic       busy_q, done_q, sel_rst_n_q, inc_q, ena_q, um_rst_n_q;
`ifdef TT_CTRL_SEQ_FASTSEL_EN
    logic       valid_q, valid_d;
`endif

    assign sel_ack        = sel_req & ~busy_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign cur_addr       = cur_q;
    assign ctrl_sel_rst_n = sel_rst_n_q;
    assign ctrl_sel_inc   = inc_q;
    assign ctrl_ena       = ena_q;
    assign um_rst_n       = um_rst_n_q;

    // cur_addr tracks the chain counter: it is cleared on entry to SRST and bumped on entry to INC_HI.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
`ifdef TT_CTRL_SEQ_FASTSEL_EN
        valid_d = valid_q;
`endif
        case (state_q)
            IDLE, RUN: begin
                if (sel_ack) begin
                    tgt_d   = sel_addr;
                    off_d   = 1'b0;
                    state_d = DIS;
                end else if (state_q == RUN && sel_off) begin
                    off_d   = 1'b1;
                    state_d = DIS;
                end
            end
            DIS: begin
                if (off_q) begin
                    state_d = IDLE;
`ifdef TT_CTRL_SEQ_FASTSEL_EN
                end else if (valid_q && tgt_q > cur_q) begin
                    state_d = INC_HI;
                    cur_d   = cur_q + 10'd1;
                end else if (valid_q && tgt_q == cur_q) begin
                    state_d = URST;
                    cnt_d   = URST_LOAD;
`endif
                end else begin
                    state_d = SRST;
                    cur_d   = '0;
                    cnt_d   = SRST_LOAD;
`ifdef TT_CTRL_SEQ_FASTSEL_EN
                    valid_d = 1'b1;
`endif
                end
            end
            SRST, INC_LO: begin
                if (state_q == SRST && cnt_q != '0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (cur_q != tgt_q) begin
                    state_d = INC_HI;
                    cur_d   = cur_q + 10'd1;
                end else begin
                    state_d = URST;
                    cnt_d   = URST_LOAD;
                end
            end
            INC_HI: state_d = INC_LO;
            URST: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each registered output lines up with its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tgt_q       <= '0;
            cur_q       <= '0;
            cnt_q       <= '0;
            off_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sel_rst_n_q <= 1'b0;
            inc_q       <= 1'b0;
            ena_q       <= 1'b0;
            um_rst_n_q  <= 1'b0;
`ifdef TT_CTRL_SEQ_FASTSEL_EN
            valid_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            busy_q      <= (state_d != IDLE) && (state_d != RUN);
            done_q      <= (state_d == RUN) && (state_q != RUN);
            sel_rst_n_q <= (state_d != SRST);
            inc_q       <= (state_d == INC_HI);
            ena_q       <= (state_d == URST) || (state_d == RUN);
            um_rst_n_q  <= (state_d == RUN);
`ifdef TT_CTRL_SEQ_FASTSEL_EN
            valid_q     <= valid_d;
`endif
        end
    end

endmodule
